maskmul_top_formal_verification: RTL and testbench

- First-order Boolean-masked multiplier over GF(2^2), field polynomial x^2+x+1.
- Takes masked operands am = a^ma and bm = b^mb, their masks ma and mb, and a fresh output mask mq.
- Produces registered masked product qm such that qm ^ mq = a·b in GF(4).
- Top-level formal/verification wrapper; all buses are flattened to single-bit ports.

---
 rtl/maskmul_top_formal_verification.sv | 94 +++++++++
 tb/tb_maskmul_top_formal_verification.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/maskmul_top_formal_verification.sv
// First-order Boolean-masked GF(2^2) multiplier (poly x^2+x+1), flattened-port wrapper.
// Define MASKMUL_SHARE_REG_EN to register the partial products and mq ahead of the XOR chain.

module gf4_mul (
  input  logic [1:0] x,
  input  logic [1:0] y,
  output logic [1:0] c
);
  assign c[1] = (x[1] & y[1]) ^ (x[1] & y[0]) ^ (x[0] & y[1]);
  assign c[0] = (x[0] & y[0]) ^ (x[1] & y[1]);
endmodule

module maskmul_top_formal_verification (
  input  logic clk,
  input  logic reset,
  input  logic am_0_,
  input  logic am_1_,
  input  logic bm_0_,
  input  logic bm_1_,
  input  logic ma_0_,
  input  logic ma_1_,
  input  logic mb_0_,
  input  logic mb_1_,
  input  logic mq_0_,
  input  logic mq_1_,
  output logic qm_0_,
  output logic qm_1_
);
  localparam int NPP = 4;

  logic [1:0] am, bm, ma, mb, mq;
  logic [1:0] ambm, ammb, bmma, mamb;
  logic [1:0] t1, t2, t3, qnext, qm_q;
  logic [NPP-1:0][1:0] op_x, op_y, pp;

  assign am = {am_1_, am_0_};
  assign bm = {bm_1_, bm_0_};
  assign ma = {ma_1_, ma_0_};
  assign mb = {mb_1_, mb_0_};
  assign mq = {mq_1_, mq_0_};

  // Lane order: 0=am*bm, 1=am*mb, 2=bm*ma, 3=ma*mb
  assign op_x = {ma, bm, am, am};
  assign op_y = {mb, ma, mb, bm};

  for (genvar i = 0; i < NPP; i++) begin : g_pp
    gf4_mul u_mul (.x(op_x[i]), .y(op_y[i]), .c(pp[i]));
  end

  assign ambm = pp[0];
  assign ammb = pp[1];
  assign bmma = pp[2];
  assign mamb = pp[3];

`ifdef MASKMUL_SHARE_REG_EN
  logic [1:0] ambm_r, ammb_r, bmma_r, mamb_r, mq_r;

  // Register boundary keeps multiply-layer glitches out of the compression chain.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ambm_r <= '0;
      ammb_r <= '0;
      bmma_r <= '0;
      mamb_r <= '0;
      mq_r   <= '0;
    end else begin
      ambm_r <= ambm;
      ammb_r <= ammb;
      bmma_r <= bmma;
      mamb_r <= mamb;
      mq_r   <= mq;
    end
  end

  assign t1 = mq_r ^ ambm_r;
  assign t2 = t1 ^ ammb_r;
  assign t3 = t2 ^ bmma_r;
  assign qnext = t3 ^ mamb_r;
`else
  // Fresh mask enters first so no partial sum is ever unmasked.
  assign t1 = mq ^ ambm;
  assign t2 = t1 ^ ammb;
  assign t3 = t2 ^ bmma;
  assign qnext = t3 ^ mamb;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) qm_q <= '0;
    else       qm_q <= qnext;
  end

  assign qm_0_ = qm_q[0];
  assign qm_1_ = qm_q[1];
endmodule

// File: tb/tb_maskmul_top_formal_verification.sv
// Directed + random bench for the masked GF(4) multiplier; honours MASKMUL_SHARE_REG_EN latency.

module tb_maskmul_top_formal_verification;
`ifdef MASKMUL_SHARE_REG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif
  localparam int NRND = 999;

  logic clk, reset;
  logic [1:0] am, bm, ma, mb, mq;
  wire  [1:0] qm;
  int checks, failures;

  logic [1:0] v_am[NRND], v_bm[NRND], v_ma[NRND], v_mb[NRND], v_mq[NRND];
  int h_a[4], h_b[4], h_q[4];

  maskmul_top_formal_verification dut (
    .clk(clk), .reset(reset),
    .am_0_(am[0]), .am_1_(am[1]),
    .bm_0_(bm[0]), .bm_1_(bm[1]),
    .ma_0_(ma[0]), .ma_1_(ma[1]),
    .mb_0_(mb[0]), .mb_1_(mb[1]),
    .mq_0_(mq[0]), .mq_1_(mq[1]),
    .qm_0_(qm[0]), .qm_1_(qm[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // GF(4) product table, elements {0,1,x,x+1} encoded 0..3
  function automatic logic [1:0] gmul(input logic [1:0] x, input logic [1:0] y);
    logic [1:0] r;
    r = 2'd0;
    if (x == 2'd1) r = y;
    else if (y == 2'd1) r = x;
    else if (x != 2'd0 && y != 2'd0) begin
      if (x == y) r = (x == 2'd2) ? 2'd3 : 2'd2;
      else        r = 2'd1;
    end
    return r;
  endfunction

  task automatic chk(input string tag, input logic [1:0] obs, input logic [1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_range(input string tag, input int obs, input int lo, input int hi);
    checks++;
    assert (obs >= lo && obs <= hi) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=[%0d..%0d]", tag, obs, lo, hi);
    end
  endtask

  task automatic drive(input logic [1:0] a_m, b_m, m_a, m_b, m_q);
    am = a_m; bm = b_m; ma = m_a; mb = m_b; mq = m_q;
  endtask

  task automatic apply(input string tag, input logic [1:0] a_m, b_m, m_a, m_b, m_q,
                       input logic [1:0] exp);
    drive(a_m, b_m, m_a, m_b, m_q);
    repeat (LAT) @(posedge clk);
    #1;
    chk(tag, qm, exp);
  endtask

  initial begin
    int j;
    logic [1:0] qv;
    checks = 0; failures = 0;
    for (int i = 0; i < 4; i++) begin h_a[i] = 0; h_b[i] = 0; h_q[i] = 0; end
    reset = 1'b0;
    drive(2'd2, 2'd2, 2'd0, 2'd0, 2'd0);

    // Asynchronous reset before any clock edge, with nonzero qnext pending
    #3 reset = 1'b1;
    #1 chk("reset_async", qm, 2'd0);
    repeat (2) @(posedge clk);
    #1 chk("reset_hold", qm, 2'd0);
    reset = 1'b0;
    repeat (LAT) @(posedge clk);
    #1 chk("reset_first_load", qm, 2'd3);

    apply("unmasked_2x3", 2'd2, 2'd3, 2'd0, 2'd0, 2'd0, 2'd1);
    apply("unmasked_3x3", 2'd3, 2'd3, 2'd0, 2'd0, 2'd0, 2'd2);
    apply("unmasked_1x3", 2'd1, 2'd3, 2'd0, 2'd0, 2'd0, 2'd3);
    apply("masked_3x2",   2'd1, 2'd3, 2'd2, 2'd1, 2'd2, 2'd3);
    apply("b_zero",       2'd2, 2'd2, 2'd1, 2'd2, 2'd3, 2'd3);
    apply("a_zero",       2'd3, 2'd1, 2'd3, 2'd2, 2'd1, 2'd1);

`ifdef MASKMUL_SHARE_REG_EN
    drive(2'd1, 2'd3, 2'd2, 2'd1, 2'd2);
    @(posedge clk); #1 chk("share_prev_vector", qm, 2'd1);
    @(posedge clk); #1 chk("share_two_edges", qm, 2'd3);
`endif

    // Reset mid-stream discards the held result
    apply("pre_midreset", 2'd1, 2'd3, 2'd2, 2'd1, 2'd2, 2'd3);
    #2 reset = 1'b1;
    #1 chk("midreset_async", qm, 2'd0);
    @(posedge clk); #1 chk("midreset_hold", qm, 2'd0);
    reset = 1'b0;

    for (int i = 0; i < NRND; i++) begin
      v_am[i] = 2'($urandom_range(0, 3));
      v_bm[i] = 2'($urandom_range(0, 3));
      v_ma[i] = 2'($urandom_range(0, 3));
      v_mb[i] = 2'($urandom_range(0, 3));
      v_mq[i] = 2'($urandom_range(0, 3));
    end
    for (int k = 0; k < NRND + LAT - 1; k++) begin
      if (k < NRND) drive(v_am[k], v_bm[k], v_ma[k], v_mb[k], v_mq[k]);
      @(posedge clk);
      #1;
      j = k - LAT + 1;
      if (j >= 0) begin
        qv = qm ^ v_mq[j];
        chk("random_invariant", qv, gmul(v_am[j] ^ v_ma[j], v_bm[j] ^ v_mb[j]));
        h_a[v_am[j] ^ v_ma[j]]++;
        h_b[v_bm[j] ^ v_mb[j]]++;
        if (!$isunknown(qv)) h_q[qv]++;
      end
    end

    for (int i = 0; i < 4; i++) begin
      chk_range($sformatf("hist_a[%0d]", i), h_a[i], 150, 350);
      chk_range($sformatf("hist_b[%0d]", i), h_b[i], 150, 350);
    end
    chk_range("hist_q[0]", h_q[0], 370, 505);
    for (int i = 1; i < 4; i++)
      chk_range($sformatf("hist_q[%0d]", i), h_q[i], 130, 250);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
